// File: rtl/mux21_rr_arbiter_if.sv
// rtl/mux21_rr_arbiter_if.sv - request/data/grant bundle between pads and the mux arbiter
interface mux21_rr_arbiter_if #(
    parameter int WIDTH = 1
);
    logic [1:0]       req;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [1:0]       gnt;
    logic             sel;
    logic [WIDTH-1:0] y;
    logic             busy;

    modport master (
        output req, in0, in1,
        input  gnt, sel, y, busy
    );

    modport slave (
        input  req, in0, in1,
        output gnt, sel, y, busy
    );
endinterface

// File: rtl/mux21_rr_arbiter.sv
// rtl/mux21_rr_arbiter.sv - two-requester round-robin arbiter owning a 2:1 mux select
module mux21_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    mux21_rr_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT0 = 2'd1;
    localparam logic [1:0] S_GNT1 = 2'd2;
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [3:0]       hold_cnt;
    logic [3:0]       hold_nxt;
    logic             last;
    logic             last_nxt;
    logic [1:0]       gnt_q;
    logic             sel_q;
    logic             busy_q;
    logic             owner;
    logic             own_req;
    logic             oth_req;
    logic [WIDTH-1:0] y_mux;

    function automatic logic [1:0] grant_state(input logic who);
        return who ? S_GNT1 : S_GNT0;
    endfunction

    assign owner   = (state == S_GNT1);
    assign own_req = owner ? bus.req[1] : bus.req[0];
    assign oth_req = owner ? bus.req[0] : bus.req[1];

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        last_nxt  = last;
        case (state)
            S_IDLE: begin
                // On contention the requester that did not own the mux last goes first.
                if (bus.req[0] && (!bus.req[1] || last)) begin
                    state_nxt = S_GNT0;
                    hold_nxt  = '0;
                end else if (bus.req[1]) begin
                    state_nxt = S_GNT1;
                    hold_nxt  = '0;
                end
            end
            S_GNT0, S_GNT1: begin
                if (!own_req) begin
                    last_nxt  = owner;
                    hold_nxt  = '0;
                    state_nxt = oth_req ? grant_state(!owner) : S_IDLE;
                end else if (oth_req && (hold_cnt == HOLD_LAST)) begin
                    last_nxt  = owner;
                    hold_nxt  = '0;
                    state_nxt = grant_state(!owner);
                end else if (hold_cnt != HOLD_LAST) begin
                    // Saturating keeps a late competitor one cycle away from service.
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            last     <= 1'b1;
            gnt_q    <= 2'b00;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (ena) begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            last     <= last_nxt;
            gnt_q    <= {state_nxt == S_GNT1, state_nxt == S_GNT0};
            busy_q   <= (state_nxt == S_GNT0) || (state_nxt == S_GNT1);
            // sel is left alone on return to idle; y is gated by gnt instead.
            if (state_nxt == S_GNT0) begin
                sel_q <= 1'b0;
            end else if (state_nxt == S_GNT1) begin
                sel_q <= 1'b1;
            end
        end
    end

    assign y_mux    = (gnt_q != 2'b00) ? (sel_q ? bus.in1 : bus.in0) : '0;
    assign bus.y    = y_mux;
    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// tb/tb_mux21_rr_arbiter.sv - directed and randomized checks of mux21_rr_arbiter against a behavioural model
module tb_mux21_rr_arbiter;
    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    // Model: who owns the mux, how many cycles it has owned it, who owned it last.
    int   m_owner;
    int   m_run;
    int   m_last;
    logic m_sel;

    mux21_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux21_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = 1;
        m_sel   = 1'b0;
    endtask

    task automatic take(input int who);
        m_owner = who;
        m_run   = 1;
        m_sel   = (who == 1);
    endtask

    task automatic model_step();
        int other;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!ena) return;
        if (m_owner < 0) begin
            if (bus.req == 2'b11) take(1 - m_last);
            else if (bus.req[0]) take(0);
            else if (bus.req[1]) take(1);
        end else begin
            other = 1 - m_owner;
            if (!bus.req[m_owner]) begin
                m_last = m_owner;
                if (bus.req[other]) take(other);
                else m_owner = -1;
            end else if (bus.req[other] && m_run >= MAX_HOLD) begin
                m_last = m_owner;
                take(other);
            end else begin
                m_run++;
            end
        end
    endtask

    function automatic logic [1:0] m_gnt();
        if (m_owner < 0) return 2'b00;
        return (m_owner == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [WIDTH-1:0] m_y();
        if (m_owner < 0) return '0;
        return m_sel ? bus.in1 : bus.in0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_gnt", bus.gnt, m_gnt());
            check("cmp_sel", bus.sel, m_sel);
            check("cmp_busy", bus.busy, (m_owner >= 0));
            check("cmp_y", bus.y, m_y());
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_y;
        rst_n   = 1'b0;
        ena     = 1'b1;
        bus.req = 2'b00;
        bus.in0 = '0;
        bus.in1 = '0;
        model_reset();
        step();
        step();
        chk_en = 1'b1;
        check("rst_gnt", bus.gnt, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_y", bus.y, 0);

        // single request
        rst_n   = 1'b1;
        bus.req = 2'b01;
        bus.in0 = 4'h1;
        bus.in1 = 4'h0;
        step();
        check("single_gnt", bus.gnt, 2'b01);
        check("single_sel", bus.sel, 1'b0);
        check("single_y", bus.y, 4'h1);
        check("single_busy", bus.busy, 1'b1);
        bus.req = 2'b00;
        step();
        check("drop_gnt", bus.gnt, 2'b00);
        check("drop_y", bus.y, 0);

        // asynchronous reset mid-grant
        bus.req = 2'b10;
        step();
        check("pre_rst_gnt", bus.gnt, 2'b10);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_gnt", bus.gnt, 2'b00);
        check("async_sel", bus.sel, 1'b0);
        check("async_busy", bus.busy, 1'b0);
        step();
        rst_n = 1'b1;

        // continuous contention: 4 cycles each, alternating
        bus.req = 2'b11;
        for (int i = 0; i < 16; i++) begin
            step();
            check("contend_gnt", bus.gnt, (((i / 4) % 2) == 0) ? 2'b01 : 2'b10);
        end

        // early release at hold_cnt=1
        do_reset();
        bus.in0 = 4'h5;
        bus.in1 = 4'hA;
        bus.req = 2'b11;
        step();
        step();
        check("early_pre_gnt", bus.gnt, 2'b01);
        bus.req = 2'b10;
        step();
        check("early_gnt", bus.gnt, 2'b10);
        check("early_sel", bus.sel, 1'b1);
        check("early_y", bus.y, 4'hA);

        // saturation then late competitor
        do_reset();
        bus.req = 2'b10;
        for (int i = 0; i < 10; i++) begin
            step();
            check("sat_gnt", bus.gnt, 2'b10);
        end
        bus.req = 2'b11;
        step();
        check("sat_switch_gnt", bus.gnt, 2'b01);

        // ena freeze in GNT1 at hold_cnt=2
        do_reset();
        bus.req = 2'b10;
        step();
        step();
        step();
        bus.req = 2'b11;
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_y   = WIDTH'(i + 3);
            bus.in1 = exp_y;
            step();
            check("frz_gnt", bus.gnt, 2'b10);
            check("frz_y", bus.y, exp_y);
        end
        ena = 1'b1;
        step();
        check("thaw1_gnt", bus.gnt, 2'b10);
        step();
        check("thaw2_gnt", bus.gnt, 2'b01);

        // fairness after idle
        do_reset();
        bus.req = 2'b10;
        step();
        bus.req = 2'b00;
        step();
        check("fair_idle_gnt", bus.gnt, 2'b00);
        bus.req = 2'b11;
        step();
        check("fair0_gnt", bus.gnt, 2'b01);
        bus.req = 2'b00;
        step();
        bus.req = 2'b11;
        step();
        check("fair1_gnt", bus.gnt, 2'b10);

        // randomized traffic, occasional freeze and reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.req[0] = ($urandom_range(0, 3) != 0);
            bus.req[1] = ($urandom_range(0, 3) != 0);
            ena        = ($urandom_range(0, 9) != 0);
            bus.in0    = WIDTH'($urandom);
            bus.in1    = WIDTH'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            step();
        end
        rst_n = 1'b1;
        ena   = 1'b1;
        step();
        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
